// File: rtl/skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// skew_feeder_pkg
//   Shared definitions for the diagonal skew feeder and the array controller:
//   default geometry and the tile FSM state encoding.
// -----------------------------------------------------------------------------
package skew_feeder_pkg;

  localparam int DEFAULT_N      = 16;  // lanes = systolic array edge length
  localparam int DEFAULT_DATA_W = 8;   // bits per operand element

  // Encodings are fixed because the array controller decodes the same values.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no tile open
    ST_STREAM = 2'd1,  // tile open, rows being accepted
    ST_DRAIN  = 2'd2   // last row accepted, flushing the wavefront
  } state_e;

endpackage

// File: rtl/skew_feeder_lane.sv
// -----------------------------------------------------------------------------
// skew_feeder_lane
//   One lane of the skew feeder: an enable-gated delay line of DEPTH stages
//   carrying an element and its valid bit. All stages shift together when
//   en_i is high and hold when it is low.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset, clears every stage
//   en_i         advance the line this cycle
//   data_i       element entering stage 0 (zero for bubbles)
//   valid_i      valid bit entering stage 0
//   data_o       element leaving the last stage
//   valid_o      valid bit of the last stage
//   any_valid_o  some stage of the line holds a valid element
// -----------------------------------------------------------------------------
module skew_feeder_lane #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              any_valid_o
);

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    data_d     = data_q;
    valid_d    = valid_q;
    data_d[0]  = data_i;
    valid_d[0] = valid_i;
    for (int k = 1; k < DEPTH; k++) begin
      data_d[k]  = data_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data stages are reset as well as the valid bits; the array
      // must see zero operands after reset, not stale ones.
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (en_i) begin
      // NOTE: state registers use non-blocking assignment so every stage
      // samples its predecessor's pre-edge value.
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o      = data_q[DEPTH-1];
  assign valid_o     = valid_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/skew_feeder.sv
// -----------------------------------------------------------------------------
// skew_feeder
//   Accepts one N-lane operand vector per cycle and emits it diagonally
//   skewed (lane i delayed i+1 cycles) to feed a systolic array edge.
//   Supports array back-pressure (stall), bubble insertion when no row is
//   accepted, tile framing with in_last, and an automatic drain at tile end.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset, discards all in-flight data
//   in_valid   in_vec / in_last valid this cycle
//   in_ready   feeder accepts a row this cycle (combinational)
//   in_vec     row, lane i = in_vec[i*DATA_W +: DATA_W]
//   in_last    accepted row is the last row of the tile
//   stall      freezes every pipeline stage and the FSM
//   out_vec    skewed elements, same lane packing as in_vec
//   out_valid  per-lane element valid
//   out_last   lane N-1 is carrying the last row's element
//   tile_done  tile completion, coincident with out_last
//   busy       tile open or any element still in flight
// -----------------------------------------------------------------------------
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_vec,
  input  logic                in_last,
  input  logic                stall,
  output logic [N*DATA_W-1:0] out_vec,
  output logic [N-1:0]        out_valid,
  output logic                out_last,
  output logic                tile_done,
  output logic                busy
);

  state_e         state_q, state_d;
  logic           advance;
  logic           accept;
  logic [N-1:0]   last_q, last_d;
  logic [N-1:0]   lane_busy;

  assign advance = !stall;
  assign accept  = in_valid & in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = in_last ? ST_DRAIN : ST_STREAM;
      ST_STREAM: if (accept && in_last) state_d = ST_DRAIN;
      // Leave only on an advancing cycle so a stalled out_last is one completion.
      ST_DRAIN:  if (advance && out_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = advance && (state_q != ST_DRAIN);
  end

  // --------------------------------------------------------- last-bit pipe
  // Travels alongside lane N-1 (depth N) so out_last marks its final element.
  always_comb begin
    last_d    = last_q;
    last_d[0] = accept & in_last;
    for (int k = 1; k < N; k++) begin
      last_d[k] = last_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (advance) begin
      last_q <= last_d;
    end
  end

  assign out_last = last_q[N-1];
  // Held high through a stall; the FSM leaves DRAIN only on an advancing
  // cycle, so each tile produces exactly one rising edge.
  assign tile_done = out_last;

  // ------------------------------------------------------------- lanes
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] lane_in;

    // Bubbles carry zero data so the array MACs see neutral operands.
    assign lane_in = accept ? in_vec[i*DATA_W +: DATA_W] : '0;

    skew_feeder_lane #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en_i        (advance),
      .data_i      (lane_in),
      .valid_i     (accept),
      .data_o      (out_vec[i*DATA_W +: DATA_W]),
      .valid_o     (out_valid[i]),
      .any_valid_o (lane_busy[i])
    );
  end

  assign busy = (state_q != ST_IDLE) || (|lane_busy) || (|last_q);

endmodule

// File: tb/tb_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_skew_feeder
//   Self-checking bench for skew_feeder. The reference model counts advancing
//   cycles and records, per lane, the advance count at which each accepted
//   element must be on the output; a monitor compares every cycle. A second
//   instance with N=1, DATA_W=32 is checked against its own small model.
// -----------------------------------------------------------------------------
module tb_skew_feeder;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int W1 = 32;

  typedef struct {
    int           due;   // advance count at which the element is on the output
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_vec;
  logic           in_last;
  logic           stall;
  logic [N*W-1:0] out_vec;
  logic [N-1:0]   out_valid;
  logic           out_last;
  logic           tile_done;
  logic           busy;

  logic           rst1;
  logic           in_valid1;
  logic           in_ready1;
  logic [W1-1:0]  in_vec1;
  logic           in_last1;
  logic           stall1;
  logic [W1-1:0]  out_vec1;
  logic [0:0]     out_valid1;
  logic           out_last1;
  logic           tile_done1;
  logic           busy1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  skew_feeder #(.N(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_last   (in_last),
    .stall     (stall),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_last  (out_last),
    .tile_done (tile_done),
    .busy      (busy)
  );

  skew_feeder #(.N(1), .DATA_W(W1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_vec    (in_vec1),
    .in_last   (in_last1),
    .stall     (stall1),
    .out_vec   (out_vec1),
    .out_valid (out_valid1),
    .out_last  (out_last1),
    .tile_done (tile_done1),
    .busy      (busy1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  exp_t lane_q [N][$];
  int   adv_cnt   = 0;
  int   last_due  = 0;
  bit   pending   = 0;  // last row accepted, its completion not yet passed
  bit   in_tile   = 0;  // rows accepted since the last in_last
  bit   seen_edge = 0;
  bit   acc;
  int   tiles_exp = 0;
  int   tiles_got = 0;
  bit   prev_td   = 0;

  always @(posedge clk) begin
    seen_edge = 1'b1;
    if (rst) begin
      for (int i = 0; i < N; i++) lane_q[i].delete();
      pending = 1'b0;
      in_tile = 1'b0;
    end else if (!stall) begin
      acc = in_valid && !pending;
      if (pending && adv_cnt == last_due) begin
        pending = 1'b0;
        tiles_exp++;
      end
      if (acc) begin
        for (int i = 0; i < N; i++)
          lane_q[i].push_back('{due: adv_cnt + i + 1, data: in_vec[i*W +: W]});
        if (in_last) begin
          pending  = 1'b1;
          in_tile  = 1'b0;
          last_due = adv_cnt + N;
        end else begin
          in_tile = 1'b1;
        end
      end
      adv_cnt++;
    end
  end

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    bit           exp_v;
    logic [W-1:0] exp_d;
    bit           any_q;
    bit           exp_last;
    if (seen_edge) begin
      any_q = 1'b0;
      for (int i = 0; i < N; i++) begin
        while (lane_q[i].size() > 0 && lane_q[i][0].due < adv_cnt)
          void'(lane_q[i].pop_front());
        exp_v = (lane_q[i].size() > 0) && (lane_q[i][0].due == adv_cnt);
        exp_d = exp_v ? lane_q[i][0].data : '0;
        if (lane_q[i].size() > 0) any_q = 1'b1;
        check($sformatf("lane%0d_valid", i), 64'(out_valid[i]), 64'(exp_v));
        check($sformatf("lane%0d_data", i), 64'(out_vec[i*W +: W]), 64'(exp_d));
      end
      exp_last = pending && (adv_cnt == last_due);
      check("out_last", 64'(out_last), 64'(exp_last));
      check("tile_done", 64'(tile_done), 64'(exp_last));
      check("in_ready", 64'(in_ready), 64'(!stall && !pending));
      check("busy", 64'(busy), 64'(pending || in_tile || any_q));
      if (tile_done && !prev_td) tiles_got++;
      prev_td = tile_done;
    end
  end

  // ---------------------------------------------------- N=1 model/monitor
  bit            e1_ready = 1'b1;
  bit            e1_valid = 1'b0;
  logic [W1-1:0] e1_data  = '0;
  bit            seen_edge1 = 0;
  bit            done1 = 0;

  always @(posedge clk) begin
    bit a1;
    seen_edge1 = 1'b1;
    if (rst1) begin
      e1_ready = 1'b1;
      e1_valid = 1'b0;
      e1_data  = '0;
    end else begin
      // Every row is a one-row tile: an accept is followed by one drain cycle.
      a1       = in_valid1 && e1_ready;
      e1_valid = a1;
      e1_data  = a1 ? in_vec1 : '0;
      e1_ready = !a1;
    end
  end

  always @(negedge clk) begin
    if (seen_edge1) begin
      check("n1_in_ready", 64'(in_ready1), 64'(e1_ready));
      check("n1_out_valid", 64'(out_valid1), 64'(e1_valid));
      check("n1_out_vec", 64'(out_vec1), 64'(e1_data));
      check("n1_out_last", 64'(out_last1), 64'(e1_valid));
      check("n1_tile_done", 64'(tile_done1), 64'(e1_valid));
      check("n1_busy", 64'(busy1), 64'(e1_valid));
    end
  end

  initial begin
    rst1 = 1'b1; in_valid1 = 1'b0; in_vec1 = '0; in_last1 = 1'b1; stall1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    in_valid1 = 1'b1;
    in_vec1   = 32'hDEADBEEF;
    @(posedge clk); #1;
    for (int k = 0; k < 60; k++) begin
      in_valid1 = ($urandom_range(0, 4) != 0);
      in_vec1   = $urandom;
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    done1 = 1'b1;
  end

  // ------------------------------------------------------------ stimulus
  task automatic cyc(input logic v, input logic [N*W-1:0] d, input logic l, input logic s);
    in_valid = v;
    in_vec   = d;
    in_last  = l;
    stall    = s;
    @(posedge clk); #1;
  endtask

  function automatic logic [N*W-1:0] row_vec(input int r);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(16 * r + i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N*W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit model_idle();
    bit idle = !pending && !in_tile;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < lane_q[i].size(); j++)
        if (lane_q[i][j].due >= adv_cnt) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (model_idle()) done = 1'b1;
      else cyc(1'b0, '0, 1'b0, 1'b0);
    end
    check({tag, "_idle"}, 64'(done), 64'(1));
  endtask

  initial begin
    logic [N*W-1:0] ones;
    bit             closed;
    bit             hit;
    for (int i = 0; i < N; i++) ones[i*W +: W] = W'(1);

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_last = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single one-row tile, lane i = i.
    cyc(1'b1, row_vec(0), 1'b1, 1'b0);
    wait_idle("t1");

    // Four-row tile, back to back.
    for (int r = 0; r < 4; r++) cyc(1'b1, row_vec(r), r == 3, 1'b0);
    wait_idle("t2");

    // Same tile with a gap on cycle 2.
    cyc(1'b1, row_vec(0), 1'b0, 1'b0);
    cyc(1'b1, row_vec(1), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, row_vec(2), 1'b0, 1'b0);
    cyc(1'b1, row_vec(3), 1'b1, 1'b0);
    wait_idle("t3");

    // Same tile with stall on cycles 5..7.
    for (int r = 0; r < 4; r++) cyc(1'b1, row_vec(r), r == 3, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    wait_idle("t4");

    // Stall landing exactly on out_last.
    cyc(1'b1, row_vec(2), 1'b1, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (pending && adv_cnt == last_due) hit = 1'b1;
      else cyc(1'b0, '0, 1'b0, 1'b0);
    end
    check("reach_out_last", 64'(hit), 64'(1));
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);
    wait_idle("t4b");

    // Reset pulse mid-tile, then a fresh all-ones row.
    for (int r = 0; r < 6; r++) cyc(1'b1, row_vec(r), 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, ones, 1'b1, 1'b0);
    wait_idle("t5");

    // Randomized traffic with stalls, gaps and tiles of random length.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 9) < 7, rand_vec(), $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 2);
    closed = !in_tile;
    for (int k = 0; k < 100 && !closed; k++) begin
      cyc(1'b1, rand_vec(), 1'b1, 1'b0);
      closed = !in_tile;
    end
    check("close_tile", 64'(closed), 64'(1));
    wait_idle("rand");

    for (int k = 0; k < 200 && !done1; k++) @(posedge clk);
    #1;
    check("n1_done", 64'(done1), 64'(1));
    check("tile_done_rises", 64'(tiles_got), 64'(tiles_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog timeout");
  end

endmodule
